// File: rtl/verisparse_pkg.sv
// Shared verisparse types: processor command encoding, driver FSM states and bus width.
package verisparse_pkg;

  localparam int FP_DATA_BUS_WIDTH = 16;
  localparam int DEFAULT_TIMEOUT   = 65535;

  typedef enum logic [2:0] {
    CMD_NONE               = 3'd0,
    LOAD_SENSING_MATRIX    = 3'd1,
    COMPUTE_INNER_PRODUCTS = 3'd2,
    LOAD_ATOM_SCALE_FACTOR = 3'd3
  } vs_dict_proc_command_t;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_ISSUE        = 3'd1,
    ST_LOAD_STREAM  = 3'd2,
    ST_COMPUTE_WAIT = 3'd3,
    ST_ASF_WAIT     = 3'd4,
    ST_COMPLETE     = 3'd5
  } vs_dict_proc_state_t;

  function automatic logic cmd_is_known(input vs_dict_proc_command_t c);
    return (c == LOAD_SENSING_MATRIX) || (c == COMPUTE_INNER_PRODUCTS) ||
           (c == LOAD_ATOM_SCALE_FACTOR);
  endfunction

  function automatic vs_dict_proc_state_t wait_state_for(input vs_dict_proc_command_t c);
    case (c)
      LOAD_SENSING_MATRIX:    return ST_LOAD_STREAM;
      COMPUTE_INNER_PRODUCTS: return ST_COMPUTE_WAIT;
      default:                return ST_ASF_WAIT;
    endcase
  endfunction

endpackage

// File: rtl/vs_dict_proc_if.sv
// Handshake and data bus between the dictionary driver and the sensing-matrix processor.
interface vs_dict_proc_if;
  import verisparse_pkg::*;

  logic                         start;
  vs_dict_proc_command_t        command;
  logic [FP_DATA_BUS_WIDTH-1:0] read_data;
  logic [7:0]                   read_addr;
  logic                         write_enable;
  logic [7:0]                   write_addr;
  logic [FP_DATA_BUS_WIDTH-1:0] write_data;
  logic                         done;

  modport driver (
    output start, command, read_data,
    input  read_addr, write_enable, write_addr, write_data, done
  );

  modport processor (
    input  start, command, read_data,
    output read_addr, write_enable, write_addr, write_data, done
  );
endinterface

// File: rtl/vs_sync_ram.sv
// One-write one-read RAM with a registered read port; only the read register is reset.
module vs_sync_ram #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_p1;

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // read stage: a same-address write lands after this sample, so old data is returned
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rdata_p1 <= '0;
    else          rdata_p1 <= mem[raddr];
  end

  assign rdata = rdata_p1;

endmodule

// File: rtl/vs_dict_proc_driver.sv
// Host-side driver that issues commands to the sensing-matrix processor, feeds it data and
// collects inner products, with a watchdog that aborts a command the processor never finishes.
module vs_dict_proc_driver
  import verisparse_pkg::*;
#(
  parameter int ROWS    = 64,
  parameter int COLUMNS = 256,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                cmd_valid,
  input  vs_dict_proc_command_t               cmd,
  output logic                                cmd_ready,
  output logic                                cmd_done,
  output logic                                cmd_error,
  input  logic                                res_we,
  input  logic [7:0]                          res_addr,
  input  logic [FP_DATA_BUS_WIDTH-1:0]        res_wdata,
  input  logic [7:0]                          prod_raddr,
  output logic [FP_DATA_BUS_WIDTH-1:0]        prod_rdata,
  input  logic [FP_DATA_BUS_WIDTH-1:0]        atom_index_in,
  input  logic [FP_DATA_BUS_WIDTH-1:0]        scale_in,
  output logic [$clog2(ROWS*COLUMNS)-1:0]     mat_addr,
  input  logic [FP_DATA_BUS_WIDTH-1:0]        mat_rdata,
  vs_dict_proc_if.driver                      bus
);

  localparam int DATA_W = FP_DATA_BUS_WIDTH;
  localparam int MAT_AW = $clog2(ROWS*COLUMNS);
  localparam int ROW_AW = $clog2(ROWS);
  localparam int COL_AW = $clog2(COLUMNS);
  localparam int WD_W   = $clog2(TIMEOUT+1);
  localparam logic [MAT_AW-1:0] MAT_LAST = MAT_AW'(ROWS*COLUMNS-1);
  localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT);

  vs_dict_proc_state_t   state;
  vs_dict_proc_command_t cmd_q;
  logic [WD_W-1:0]       watchdog;
  logic                  asf_first;
  logic [DATA_W-1:0]     res_rdata_p1;
  logic                  res_wr_en;
  logic                  prod_wr_en;
  logic                  unused_addr_bits;

  function automatic logic [MAT_AW-1:0] sat_inc(input logic [MAT_AW-1:0] a);
    return (a == MAT_LAST) ? a : a + 1'b1;
  endfunction

  assign cmd_ready   = (state == ST_IDLE);
  assign cmd_done    = (state == ST_COMPLETE);
  assign bus.start   = (state == ST_ISSUE);
  assign bus.command = cmd_q;

  // the processor owns the residual RAM while it computes, so host writes are dropped then
  assign res_wr_en  = res_we && (state != ST_COMPUTE_WAIT);
  assign prod_wr_en = bus.write_enable && (state == ST_COMPUTE_WAIT);
  assign unused_addr_bits = ^{bus.read_addr[7:ROW_AW], res_addr[7:ROW_AW]};

  always_comb begin
    bus.read_data = '0;
    case (state)
      ST_LOAD_STREAM:  bus.read_data = mat_rdata;
      ST_COMPUTE_WAIT: bus.read_data = res_rdata_p1;
      ST_ASF_WAIT:     bus.read_data = asf_first ? atom_index_in : scale_in;
      default:         bus.read_data = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cmd_q     <= CMD_NONE;
      cmd_error <= 1'b0;
      mat_addr  <= '0;
      watchdog  <= '0;
      asf_first <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            watchdog <= '0;
            if (cmd_is_known(cmd)) begin
              cmd_q    <= cmd;
              mat_addr <= '0;
              state    <= ST_ISSUE;
            end else begin
              state <= ST_COMPLETE;
            end
          end
        end
        ST_ISSUE: begin
          watchdog  <= WD_W'(1);
          asf_first <= 1'b1;
          if (cmd_q == LOAD_SENSING_MATRIX) mat_addr <= sat_inc(mat_addr);
          state <= wait_state_for(cmd_q);
        end
        ST_LOAD_STREAM, ST_COMPUTE_WAIT, ST_ASF_WAIT: begin
          asf_first <= 1'b0;
          if (state == ST_LOAD_STREAM) mat_addr <= sat_inc(mat_addr);
          // watchdog holds the number of cycles elapsed since ISSUE
          if (bus.done) begin
            state <= ST_COMPLETE;
          end else if (watchdog >= WD_LIMIT) begin
            cmd_error <= 1'b1;
            state     <= ST_COMPLETE;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end
        ST_COMPLETE: state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

  vs_sync_ram #(.DEPTH(ROWS), .DATA_W(DATA_W), .ADDR_W(ROW_AW)) u_residual_ram (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (res_wr_en),
    .waddr   (res_addr[ROW_AW-1:0]),
    .wdata   (res_wdata),
    .raddr   (bus.read_addr[ROW_AW-1:0]),
    .rdata   (res_rdata_p1)
  );

  vs_sync_ram #(.DEPTH(COLUMNS), .DATA_W(DATA_W), .ADDR_W(COL_AW)) u_product_ram (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (prod_wr_en),
    .waddr   (bus.write_addr[COL_AW-1:0]),
    .wdata   (bus.write_data),
    .raddr   (prod_raddr[COL_AW-1:0]),
    .rdata   (prod_rdata)
  );

endmodule

// File: doc/vs_dict_proc_driver.md
VS_DICT_PROC_DRIVER -- requirements
Module: vs_dict_proc_driver

Interface
REQ-001 Parameters, each SHALL be: ROWS, 64, matrix rows; COLUMNS, 256, matrix columns; TIMEOUT, 65535, max cycles from start to done.
REQ-002 Ports SHALL be:
- clock  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  host command request
- cmd  in  vs_dict_proc_command_t  requested command
- cmd_ready  out  1  driver idle, accepts cmd
- cmd_done  out  1  one-cycle completion pulse
- cmd_error  out  1  sticky timeout flag
- res_we  in  1  host residual write strobe
- res_addr  in  8  residual write address
- res_wdata  in  FP_DATA_BUS_WIDTH  residual word
- prod_raddr  in  8  host product read address
- prod_rdata  out  FP_DATA_BUS_WIDTH  product word, 1-cycle latency
- atom_index_in  in  FP_DATA_BUS_WIDTH  atom location for LOAD_ATOM_SCALE_FACTOR
- scale_in  in  FP_DATA_BUS_WIDTH  scale factor for LOAD_ATOM_SCALE_FACTOR
- mat_addr  out  $clog2(ROWS*COLUMNS)  external matrix memory address, column-major
- mat_rdata  in  FP_DATA_BUS_WIDTH  matrix word, 1-cycle latency
- bus  vs_dict_proc_if.driver  processor-side port

Function
REQ-003 The block SHALL contain a ROWS-deep residual RAM and a COLUMNS-deep product RAM, both with registered read.
REQ-004 The FSM SHALL have the states IDLE, ISSUE, LOAD_STREAM, COMPUTE_WAIT, ASF_WAIT and COMPLETE.
REQ-005 cmd_ready SHALL be 1 only in IDLE; cmd_valid&&cmd_ready SHALL latch cmd and move to ISSUE.
REQ-006 ISSUE SHALL drive bus.start=1 and bus.command=latched cmd for exactly one cycle, then go to LOAD_STREAM, COMPUTE_WAIT or ASF_WAIT according to cmd.
REQ-007 For LOAD_SENSING_MATRIX, mat_addr SHALL be 0 in the ISSUE cycle and increment by 1 every cycle, saturating at ROWS*COLUMNS-1.
REQ-008 During LOAD_STREAM, bus.read_data SHALL equal mat_rdata, so that word k is sampled at the (k+1)th edge after start.
REQ-009 For COMPUTE_INNER_PRODUCTS, bus.read_data SHALL be residual_ram[bus.read_addr] registered, which gives 1-cycle latency.
REQ-010 In COMPUTE_WAIT, every edge with bus.write_enable=1 SHALL write bus.write_data into product_ram[bus.write_addr].
REQ-011 bus.write_addr SHALL wrap modulo 256.
REQ-012 For LOAD_ATOM_SCALE_FACTOR, bus.read_data SHALL be atom_index_in in the first cycle after ISSUE and scale_in in the second.
REQ-013 In any *_WAIT or LOAD_STREAM state, bus.done=1 SHALL move the FSM to COMPLETE.
REQ-014 COMPLETE SHALL pulse cmd_done for one cycle and return to IDLE.
REQ-015 A watchdog SHALL count cycles after ISSUE and reset on each new command.
REQ-016 If the watchdog reaches TIMEOUT before done, the block SHALL set cmd_error, pulse cmd_done, and return to IDLE.
REQ-017 cmd_error SHALL clear only on reset.
REQ-018 res_we SHALL be honoured only when not in COMPUTE_WAIT; writes in COMPUTE_WAIT SHALL be dropped.
REQ-019 Host product reads SHALL be allowed in any state; a simultaneous read and write to the same address SHALL return the old data.
REQ-020 cmd_valid while busy SHALL be ignored, with no queueing.
REQ-021 In IDLE, bus.read_data SHALL be 0.
REQ-022 An unknown cmd value SHALL complete as a one-cycle no-op, with no bus.start and with a cmd_done pulse.

Reset
REQ-023 Asserting reset_n low at any time, including mid-command, SHALL immediately force: FSM=IDLE, bus.start=0, bus.command=0, cmd_done=0, cmd_error=0, mat_addr=0, watchdog=0, bus.read_data=0, prod_rdata=0.
REQ-024 RAM contents SHALL NOT be reset.

Structure
REQ-025 The FSM state enum SHALL be in the shared verisparse package.
REQ-026 vs_dict_proc_command_t, FP_DATA_BUS_WIDTH and the default TIMEOUT SHALL be in the shared verisparse package.
REQ-027 The two RAMs SHALL be instances of one sub-module, vs_sync_ram (parameterised depth/width, 1W1R, registered read).

Verification
REQ-028 Scenario A: LOAD_SENSING_MATRIX with mat memory word k = k, run against vs_sensing_matrix_processor -> mat_addr 0..16383, processor phi[r][c] = c*64+r, one cmd_done.
REQ-029 Scenario B: residual all 1.0 (Q15), phi column c all equal to c -> product_ram[c] = 64*c in Q15 for c=0..255, and cmd_done follows bus.done by 1 cycle.
REQ-030 Scenario C: LOAD_ATOM_SCALE_FACTOR with atom_index_in=17, scale_in=0x4000 -> processor captures 17 and 0x4000, and cmd_done fires.
REQ-031 Scenario D: stub processor that never raises done, TIMEOUT=100 -> cmd_error=1 and cmd_done exactly 101 cycles after ISSUE.
REQ-032 Scenario E: reset_n low mid-COMPUTE_WAIT -> all outputs at reset values the same cycle; the next command executes normally.
REQ-033 Scenario F: res_we to address 5 during COMPUTE_WAIT -> residual_ram[5] unchanged; the same write in IDLE -> updated.
